jtag_master: RTL and testbench

- JTAG host-side engine: generates TCK/TMS/TDI and samples TDO to drive a JTAG/SW-DP debug target from fabric logic.
- Lets an on-board controller (board-test, self-programming, loopback checks of the debug port) issue TAP reset, IR/DR shift and idle commands without an external probe.
- Command in / response out over valid-ready handshakes. All logic runs on the system clock; TCK is derived by a divider.

---
 rtl/jtag_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_jtag_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// ============================================================================
// jtag_master : host-side JTAG engine (TAP reset, IR/DR shift, idle clocks)
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_master #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 32
) (
  input  logic                hclk,
  input  logic                ext_reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [5:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                tap_sync,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STEP_W = $clog2(MAX_BITS + 7);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  // {is shift bit, shift bit index} for TCK number 'step' of a sequence
  function automatic logic [STEP_W:0] shift_info(input logic [1:0] op, input logic [5:0] len,
                                                 input logic [STEP_W-1:0] step);
    logic [STEP_W-1:0] pre;
    logic [STEP_W-1:0] idx;
    logic              hit;
    pre = (op == OP_IR) ? STEP_W'(4) : STEP_W'(3);
    idx = step - pre;
    hit = ((op == OP_IR) || (op == OP_DR)) && (step >= pre) && (idx < STEP_W'(len));
    return {hit, idx};
  endfunction

  function automatic logic tms_of(input logic [1:0] op, input logic [5:0] len,
                                  input logic [STEP_W-1:0] step);
    logic [STEP_W:0]   si;
    logic [STEP_W-1:0] pre;
    logic              t;
    si  = shift_info(op, len, step);
    pre = (op == OP_IR) ? STEP_W'(4) : STEP_W'(3);
    case (op)
      OP_RESET: t = (step < STEP_W'(5));
      OP_IDLE:  t = 1'b0;
      default: begin
        if (step < pre)
          t = (step == '0) || ((op == OP_IR) && (step == STEP_W'(1)));
        else if (si[STEP_W])
          t = (si[STEP_W-1:0] == STEP_W'(len) - STEP_W'(1));
        else
          t = (si[STEP_W-1:0] == STEP_W'(len));   // Exit1 -> Update
      end
    endcase
    return t;
  endfunction

  function automatic logic [STEP_W-1:0] last_step(input logic [1:0] op, input logic [5:0] len);
    case (op)
      OP_RESET: return STEP_W'(5);
      OP_IR:    return STEP_W'(len) + STEP_W'(5);
      OP_DR:    return STEP_W'(len) + STEP_W'(4);
      default:  return STEP_W'(len) - STEP_W'(1);
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [5:0]          len_q, len_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic [MAX_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                tap_sync_q, tap_sync_d;

  logic                w_accept;
  logic                w_legal;
  logic                w_phase_end;
  logic                w_seq_last;
  logic [1:0]          w_nxt_op;
  logic [5:0]          w_nxt_len;
  logic [MAX_BITS-1:0] w_nxt_data;
  logic [STEP_W-1:0]   w_nxt_step;
  logic [STEP_W:0]     w_nxt_si;
  logic                w_nxt_tms;
  logic                w_nxt_tdi;
  logic [STEP_W:0]     w_cur_si;

  assign w_accept    = cmd_valid && (state_q == ST_IDLE);
  assign w_legal     = (cmd_op == OP_RESET) ||
                       ((cmd_len != 6'd0) && (int'(cmd_len) <= MAX_BITS));
  assign w_phase_end = (div_q == DIV_LAST);
  assign w_seq_last  = (step_q == last_step(op_q, len_q));

  // Pin values for the next low phase: step 0 of a new command, or step+1
  always_comb begin
    w_nxt_op   = op_q;
    w_nxt_len  = len_q;
    w_nxt_data = data_q;
    w_nxt_step = step_q + STEP_W'(1);
    if (state_q == ST_IDLE) begin
      w_nxt_op   = cmd_op;
      w_nxt_len  = cmd_len;
      w_nxt_data = cmd_data;
      w_nxt_step = '0;
    end
    w_nxt_si  = shift_info(w_nxt_op, w_nxt_len, w_nxt_step);
    w_nxt_tms = tms_of(w_nxt_op, w_nxt_len, w_nxt_step);
    w_nxt_tdi = w_nxt_si[STEP_W] &&
                (|(w_nxt_data & (MAX_BITS'(1) << w_nxt_si[STEP_W-1:0])));
    w_cur_si  = shift_info(op_q, len_q, step_q);
  end

  always_ff @(posedge hclk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RESET;
      len_q      <= '0;
      data_q     <= '0;
      step_q     <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tap_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      step_q     <= step_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tap_sync_q <= tap_sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = w_legal ? ST_RUN : ST_RESP;
      ST_RUN:  if (w_phase_end && tck_q && w_seq_last) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    step_d     = step_q;
    div_d      = div_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tap_sync_d = tap_sync_q;
    if (w_accept) begin
      op_d       = cmd_op;
      len_d      = cmd_len;
      data_d     = cmd_data;
      step_d     = '0;
      div_d      = '0;
      tck_d      = 1'b0;
      rsp_data_d = '0;
      rsp_err_d  = !w_legal;
      if (w_legal) begin
        tms_d = w_nxt_tms;
        tdi_d = w_nxt_tdi;
      end
    end else if (state_q == ST_RUN) begin
      if (!w_phase_end) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        if (!tck_q) begin
          tck_d = 1'b1;
          if (w_cur_si[STEP_W])
            rsp_data_d = rsp_data_q | (MAX_BITS'(tdo) << w_cur_si[STEP_W-1:0]);
        end else begin
          tck_d = 1'b0;
          if (w_seq_last) begin
            tdi_d = 1'b0;
            if (op_q == OP_RESET) tap_sync_d = 1'b1;
          end else begin
            step_d = w_nxt_step;
            tms_d  = w_nxt_tms;
            tdi_d  = w_nxt_tdi;
          end
        end
      end
    end
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q == ST_RUN);
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign tap_sync = tap_sync_q;
  assign tck      = tck_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_master.sv
// Randomised scoreboard bench for jtag_master: per-TCK pin expectations and
// per-command response expectations are queued at issue time and checked by monitors.
`default_nettype none

module tb_jtag_master;
  localparam int DIV = 2;
  localparam int MB  = 32;

  logic        hclk = 1'b0;
  logic        ext_reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, tap_sync, tck, tms, tdi, tdo;
  int          tdo_mode = 0;

  jtag_master #(.CLK_DIV(DIV), .MAX_BITS(MB)) dut (
    .hclk(hclk), .ext_reset_n(ext_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tap_sync(tap_sync),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 hclk = ~hclk;
  assign tdo = (tdo_mode == 1) ? tdi : (tdo_mode == 2) ? ~tdi : 1'b0;

  typedef struct packed { logic tms; logic tdi; logic first; } tck_exp_t;
  typedef struct packed { logic [31:0] data; logic err; logic sync; } rsp_exp_t;

  tck_exp_t tck_exp_q[$];
  rsp_exp_t rsp_exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit sync_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge hclk) cyc <= cyc + 1;

  // TCK monitor: pin values at every rising TCK edge plus TCK period
  initial begin
    int last_rise;
    tck_exp_t e;
    last_rise = 0;
    forever begin
      @(posedge tck);
      #1;
      if (tck_exp_q.size() == 0) begin
        fail_now("tck_unexpected_rise");
      end else begin
        e = tck_exp_q.pop_front();
        chk("tms_at_rise", 32'(tms), 32'(e.tms));
        chk("tdi_at_rise", 32'(tdi), 32'(e.tdi));
        if (!e.first) chk("tck_period", 32'(cyc - last_rise), 32'(2 * DIV));
      end
      last_rise = cyc;
    end
  end

  // Response monitor: compares on handshake, checks hold stability and cmd_ready
  initial begin
    bit          pend;
    bit          want_ready;
    logic [31:0] held_d;
    logic        held_e;
    rsp_exp_t    r;
    pend = 0; want_ready = 0; held_d = '0; held_e = 1'b0;
    forever begin
      @(negedge hclk);
      #1;
      if (!ext_reset_n) begin
        pend = 0;
        want_ready = 0;
        continue;
      end
      if (want_ready) begin
        chk("cmd_ready_after_handshake", 32'(cmd_ready), 32'd1);
        want_ready = 0;
      end
      if (rsp_valid) begin
        chk("cmd_ready_low_during_rsp", 32'(cmd_ready), 32'd0);
        if (pend) begin
          chk("rsp_data_stable", rsp_data, held_d);
          chk("rsp_err_stable", 32'(rsp_err), 32'(held_e));
        end
        held_d = rsp_data;
        held_e = rsp_err;
        pend   = 1;
        if (rsp_ready) begin
          if (rsp_exp_q.size() == 0) begin
            fail_now("rsp_unexpected");
          end else begin
            r = rsp_exp_q.pop_front();
            chk("rsp_data", rsp_data, r.data);
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
            chk("tap_sync", 32'(tap_sync), 32'(r.sync));
          end
          pend = 0;
          want_ready = 1;
        end
      end
    end
  end

  // Reference model: TMS/TDI list per TCK and the expected response
  task automatic model(input int op, input int len, input logic [31:0] data, input int mode);
    bit          legal;
    bit          tl[$];
    bit          dl[$];
    logic [63:0] mask;
    logic [31:0] exp_d;
    tck_exp_t    e;
    rsp_exp_t    r;
    legal = (op == 0) || (len >= 1 && len <= MB);
    exp_d = '0;
    if (legal) begin
      if (op == 0) begin
        for (int i = 0; i < 6; i++) tl.push_back(i < 5);
      end else if (op == 1) begin
        tl.push_back(1); tl.push_back(1); tl.push_back(0); tl.push_back(0);
      end else if (op == 2) begin
        tl.push_back(1); tl.push_back(0); tl.push_back(0);
      end
      while (dl.size() < tl.size()) dl.push_back(0);
      if (op == 1 || op == 2) begin
        for (int i = 0; i < len; i++) begin
          tl.push_back(i == len - 1);
          dl.push_back(data[i]);
        end
        tl.push_back(1); dl.push_back(0);
        tl.push_back(0); dl.push_back(0);
        mask = (64'd1 << len) - 64'd1;
        if (mode == 1) exp_d = data & mask[31:0];
        else if (mode == 2) exp_d = ~data & mask[31:0];
      end else if (op == 3) begin
        for (int i = 0; i < len; i++) begin
          tl.push_back(0);
          dl.push_back(0);
        end
      end
      for (int i = 0; i < tl.size(); i++) begin
        e.tms = tl[i]; e.tdi = dl[i]; e.first = (i == 0);
        tck_exp_q.push_back(e);
      end
    end
    if (op == 0) sync_model = 1'b1;
    r.data = exp_d; r.err = !legal; r.sync = sync_model;
    rsp_exp_q.push_back(r);
  endtask

  task automatic drive_cmd(input int op, input int len, input logic [31:0] data);
    int t;
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_len   = len[5:0];
    cmd_data  = data;
    t = 0;
    while (!cmd_ready && t < 500) begin
      @(negedge hclk);
      t++;
    end
    if (t >= 500) fail_now("cmd_ready_timeout");
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input int op, input int len, input logic [31:0] data,
                       input int mode, input int hold, input bit early);
    int t;
    model(op, len, data, mode);
    tdo_mode  = mode;
    rsp_ready = early;
    drive_cmd(op, len, data);
    t = 0;
    while (!rsp_valid && t < 2000) begin
      @(negedge hclk);
      t++;
    end
    if (t >= 2000) fail_now("rsp_valid_timeout");
    if (!early) begin
      repeat (hold) @(negedge hclk);
      rsp_ready = 1'b1;
    end
    @(negedge hclk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, len, sel;
    ext_reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge hclk);
    chk("reset_tck", 32'(tck), 32'd0);
    chk("reset_tms", 32'(tms), 32'd1);
    chk("reset_tdi", 32'(tdi), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tap_sync", 32'(tap_sync), 32'd0);
    ext_reset_n = 1'b1;
    @(negedge hclk);

    issue(2, 4, 32'h9, 1, 1, 0);               // shift before any TAP reset
    issue(0, 0, 32'h0, 0, 1, 0);
    issue(2, 8, 32'hA5, 1, 0, 0);
    issue(1, 5, 32'h1F, 0, 2, 0);
    issue(2, 32, 32'hDEADBEEF, 1, 20, 0);
    issue(2, 0, 32'hFFFF_FFFF, 1, 1, 0);
    issue(3, 33, 32'h0, 0, 1, 0);
    issue(3, 7, 32'h0, 0, 0, 1);
    issue(1, 1, 32'h1, 2, 0, 1);

    // Asynchronous reset in the middle of a 16-bit DR shift
    model(2, 16, 32'h0000_C3A5, 1);
    tdo_mode = 1;
    drive_cmd(2, 16, 32'h0000_C3A5);
    repeat (40) @(negedge hclk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    #2 ext_reset_n = 1'b0;
    #1;
    chk("abort_tck", 32'(tck), 32'd0);
    chk("abort_tms", 32'(tms), 32'd1);
    chk("abort_tdi", 32'(tdi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tap_sync", 32'(tap_sync), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    tck_exp_q.delete();
    rsp_exp_q.delete();
    sync_model = 1'b0;
    @(negedge hclk);
    ext_reset_n = 1'b1;
    @(negedge hclk);
    issue(0, 0, 32'h0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      op  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63));
      else          len = int'($urandom_range(1, 32));
      issue(op, len, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge hclk);
    chk("tck_expectations_drained", 32'(tck_exp_q.size()), 32'd0);
    chk("rsp_expectations_drained", 32'(rsp_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
